system_bus: RTL and testbench



---
 rtl/system_bus_if.sv | 51 +++++
 rtl/system_bus.sv | 144 ++++++++++++++
 tb/tb_system_bus.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/system_bus_if.sv
// Bundle of the system bus signals shared by the two masters, three slaves and the interconnect.
// The slave modport is the interconnect's view, and the master modport is the attached agents' view.
interface system_bus_if #(
    parameter int unsigned AW = 14,
    parameter int unsigned DW = 32
);
    logic          req1;
    logic          req2;
    logic          sb_lock_m1;
    logic          sb_lock_m2;
    logic [1:0]    resp;
    logic [1:0]    resp0;
    logic [1:0]    resp1;
    logic [1:0]    resp2;
    logic [AW-1:0] HADDR_M1;
    logic [AW-1:0] HADDR_M2;
    logic [DW-1:0] RDATA_S0;
    logic [DW-1:0] RDATA_S1;
    logic [DW-1:0] RDATA_S2;
    logic [DW-1:0] WDATA_M1;
    logic [DW-1:0] WDATA_M2;
    logic [1:0]    sb_split_ar;

    logic          gnt1;
    logic          gnt2;
    logic [1:0]    sb_masters;
    logic          sb_mastlock;
    logic [DW-1:0] RDATA;
    logic [AW-1:0] HADDR;
    logic          scl_0;
    logic          scl_1;
    logic          scl_2;
    logic [1:0]    sel_slave;
    logic [DW-1:0] WDATA;

    modport slave (
        input  req1, req2, sb_lock_m1, sb_lock_m2, resp, resp0, resp1, resp2,
               HADDR_M1, HADDR_M2, RDATA_S0, RDATA_S1, RDATA_S2, WDATA_M1, WDATA_M2,
               sb_split_ar,
        output gnt1, gnt2, sb_masters, sb_mastlock, RDATA, HADDR, scl_0, scl_1, scl_2,
               sel_slave, WDATA
    );

    modport master (
        output req1, req2, sb_lock_m1, sb_lock_m2, resp, resp0, resp1, resp2,
               HADDR_M1, HADDR_M2, RDATA_S0, RDATA_S1, RDATA_S2, WDATA_M1, WDATA_M2,
               sb_split_ar,
        input  gnt1, gnt2, sb_masters, sb_mastlock, RDATA, HADDR, scl_0, scl_1, scl_2,
               sel_slave, WDATA
    );
endinterface

// File: rtl/system_bus.sv
// Shared-bus interconnect for two masters and three slaves. It contains a registered arbiter with
// lock and split handling, address and write-data muxes, a slave decoder and a read-data mux.
module system_bus #(
    parameter int unsigned AW = 14,
    parameter int unsigned DW = 32
) (
    input logic        clk,
    input logic        rst,
    system_bus_if.slave bus
);
    // State codes are chosen to equal the sb_masters encoding.
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] OWN_M1 = 2'b01;
    localparam logic [1:0] OWN_M2 = 2'b10;

    localparam logic [1:0] RESP_RETRY = 2'b10;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [1:0]    split_q, split_d;
    logic          mastlock_q, mastlock_d;
    logic          elig1, elig2;
    logic [1:0]    pick;
    logic [1:0]    hresp;
    logic [AW-1:0] haddr;
    logic [DW-1:0] wdata;
    logic [1:0]    sel;

    assign elig1 = bus.req1 & ~split_q[0];
    assign elig2 = bus.req2 & ~split_q[1];
    assign pick  = elig1 ? OWN_M1 : (elig2 ? OWN_M2 : IDLE);

    always_comb begin
        hresp = 2'b00;
        if (bus.resp != 2'b00) begin
            hresp = bus.resp;
        end else begin
            case (sel)
                2'b00:   hresp = bus.resp0;
                2'b01:   hresp = bus.resp1;
                2'b10:   hresp = bus.resp2;
                default: hresp = 2'b00;
            endcase
        end
    end

    // A clear and a set of the same mask bit in one cycle resolves to set.
    always_comb begin
        state_d = state_q;
        split_d = split_q & ~bus.sb_split_ar;
        case (state_q)
            OWN_M1: begin
                if (hresp == RESP_SPLIT) begin
                    split_d[0] = 1'b1;
                    state_d    = elig2 ? OWN_M2 : IDLE;
                end else if (hresp == RESP_RETRY) begin
                    state_d = IDLE;
                end else if (bus.req1 || bus.sb_lock_m1) begin
                    state_d = OWN_M1;
                end else begin
                    state_d = elig2 ? OWN_M2 : pick;
                end
            end
            OWN_M2: begin
                if (hresp == RESP_SPLIT) begin
                    split_d[1] = 1'b1;
                    state_d    = elig1 ? OWN_M1 : IDLE;
                end else if (hresp == RESP_RETRY) begin
                    state_d = IDLE;
                end else if (bus.req2 || bus.sb_lock_m2) begin
                    state_d = OWN_M2;
                end else begin
                    state_d = elig1 ? OWN_M1 : pick;
                end
            end
            default: state_d = pick;
        endcase
    end

    always_comb begin
        mastlock_d = 1'b0;
        if (state_d == OWN_M1) begin
            mastlock_d = bus.sb_lock_m1;
        end else if (state_d == OWN_M2) begin
            mastlock_d = bus.sb_lock_m2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            split_q    <= 2'b00;
            mastlock_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            split_q    <= split_d;
            mastlock_q <= mastlock_d;
        end
    end

    assign bus.gnt1        = (state_q == OWN_M1);
    assign bus.gnt2        = (state_q == OWN_M2);
    assign bus.sb_masters  = state_q;
    assign bus.sb_mastlock = mastlock_q;

    always_comb begin
        haddr = '0;
        wdata = '0;
        case (state_q)
            OWN_M1: begin
                haddr = bus.HADDR_M1;
                wdata = bus.WDATA_M1;
            end
            OWN_M2: begin
                haddr = bus.HADDR_M2;
                wdata = bus.WDATA_M2;
            end
            default: begin
                haddr = '0;
                wdata = '0;
            end
        endcase
    end

    assign bus.HADDR = haddr;
    assign bus.WDATA = wdata;

    // Top two address bits pick the slave; code 11 is an unmapped hole.
    assign sel = (state_q == IDLE) ? 2'b11 : haddr[AW-1 -: 2];

    assign bus.sel_slave = sel;
    assign bus.scl_0     = (sel == 2'b00);
    assign bus.scl_1     = (sel == 2'b01);
    assign bus.scl_2     = (sel == 2'b10);

    always_comb begin
        case (sel)
            2'b00:   bus.RDATA = bus.RDATA_S0;
            2'b01:   bus.RDATA = bus.RDATA_S1;
            2'b10:   bus.RDATA = bus.RDATA_S2;
            default: bus.RDATA = '0;
        endcase
    end
endmodule

// File: tb/tb_system_bus.sv
// Scoreboard bench for system_bus: a behavioural model predicts post-edge outputs each cycle,
// queues them, and they are popped and compared just after the clock edge.
module tb_system_bus;
    localparam int unsigned AW = 14;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;

    system_bus_if #(.AW(AW), .DW(DW)) bus ();

    system_bus #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          gnt1;
        logic          gnt2;
        logic [1:0]    masters;
        logic          lock;
        logic [AW-1:0] haddr;
        logic [DW-1:0] wdata;
        logic [2:0]    scl;
        logic [1:0]    sel;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    int         m_own;   // 0 none, 1 M1, 2 M2
    logic [1:0] m_mask;
    logic       m_lock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_out(input int own, input logic lk);
        exp_t e;
        e     = '0;
        e.sel = 2'b11;
        if (own == 1) begin
            e.gnt1    = 1'b1;
            e.masters = 2'b01;
            e.haddr   = bus.HADDR_M1;
            e.wdata   = bus.WDATA_M1;
        end else if (own == 2) begin
            e.gnt2    = 1'b1;
            e.masters = 2'b10;
            e.haddr   = bus.HADDR_M2;
            e.wdata   = bus.WDATA_M2;
        end
        e.lock = lk;
        if (own != 0 && e.haddr[AW-1 -: 2] != 2'b11) begin
            e.sel = e.haddr[AW-1 -: 2];
            e.scl = 3'b001 << e.sel;
        end
        case (e.sel)
            2'b00:   e.rdata = bus.RDATA_S0;
            2'b01:   e.rdata = bus.RDATA_S1;
            2'b10:   e.rdata = bus.RDATA_S2;
            default: e.rdata = '0;
        endcase
        return e;
    endfunction

    task automatic step();
        exp_t       cur, e;
        logic [1:0] hr;
        logic       e1, e2, rel;
        int         nown;
        logic [1:0] nmask;
        logic       nlock;

        cur = model_out(m_own, m_lock);
        if (bus.resp != 2'b00)         hr = bus.resp;
        else if (cur.sel == 2'b00)     hr = bus.resp0;
        else if (cur.sel == 2'b01)     hr = bus.resp1;
        else if (cur.sel == 2'b10)     hr = bus.resp2;
        else                           hr = 2'b00;

        e1    = bus.req1 && !m_mask[0];
        e2    = bus.req2 && !m_mask[1];
        nmask = m_mask & ~bus.sb_split_ar;
        nown  = m_own;
        if (m_own == 0) begin
            nown = e1 ? 1 : (e2 ? 2 : 0);
        end else if (hr == 2'b11) begin
            nmask[m_own-1] = 1'b1;
            if (m_own == 1) nown = e2 ? 2 : 0;
            else            nown = e1 ? 1 : 0;
        end else if (hr == 2'b10) begin
            nown = 0;
        end else begin
            rel = (m_own == 1) ? !(bus.req1 || bus.sb_lock_m1) : !(bus.req2 || bus.sb_lock_m2);
            if (rel) begin
                if (m_own == 1 && e2)      nown = 2;
                else if (m_own == 2 && e1) nown = 1;
                else                       nown = e1 ? 1 : (e2 ? 2 : 0);
            end
        end
        nlock = (nown == 1) ? bus.sb_lock_m1 : ((nown == 2) ? bus.sb_lock_m2 : 1'b0);
        if (rst) begin
            nown  = 0;
            nmask = 2'b00;
            nlock = 1'b0;
        end
        m_own  = nown;
        m_mask = nmask;
        m_lock = nlock;
        exp_q.push_back(model_out(nown, nlock));

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("gnt1", 64'(bus.gnt1), 64'(e.gnt1));
        check("gnt2", 64'(bus.gnt2), 64'(e.gnt2));
        check("sb_masters", 64'(bus.sb_masters), 64'(e.masters));
        check("sb_mastlock", 64'(bus.sb_mastlock), 64'(e.lock));
        check("HADDR", 64'(bus.HADDR), 64'(e.haddr));
        check("WDATA", 64'(bus.WDATA), 64'(e.wdata));
        check("scl", 64'({bus.scl_2, bus.scl_1, bus.scl_0}), 64'(e.scl));
        check("sel_slave", 64'(bus.sel_slave), 64'(e.sel));
        check("RDATA", 64'(bus.RDATA), 64'(e.rdata));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        m_own  = 0;
        m_mask = 2'b00;
        m_lock = 1'b0;
        rst = 1'b1;
        bus.req1 = 1'b1;
        bus.req2 = 1'b0;
        bus.sb_lock_m1 = 1'b0;
        bus.sb_lock_m2 = 1'b0;
        bus.resp  = 2'b00;
        bus.resp0 = 2'b00;
        bus.resp1 = 2'b00;
        bus.resp2 = 2'b00;
        bus.HADDR_M1 = 14'd1;
        bus.HADDR_M2 = 14'd2;
        bus.WDATA_M1 = 32'd1;
        bus.WDATA_M2 = 32'd2;
        bus.RDATA_S0 = 32'h0;
        bus.RDATA_S1 = 32'h1111_1111;
        bus.RDATA_S2 = 32'h2222_2222;
        bus.sb_split_ar = 2'b00;

        // Reset held with a pending request
        steps(5);
        check("tp_reset_sel", 64'(bus.sel_slave), 64'h3);
        rst = 1'b0;
        step();
        check("tp_first_gnt1", 64'(bus.gnt1), 64'h1);
        bus.RDATA_S0 = 32'hA0A0_5050;

        // Hand-over M1 -> M2 -> M1
        bus.req1 = 1'b0; bus.req2 = 1'b1;
        steps(2);
        check("tp_m2_owns", 64'(bus.sb_masters), 64'h2);
        bus.req1 = 1'b1; bus.req2 = 1'b0;
        steps(2);

        // Lock keeps M1 after its request drops
        bus.sb_lock_m1 = 1'b1;
        step();
        bus.req1 = 1'b0; bus.req2 = 1'b1;
        steps(2);
        check("tp_lock_hold", 64'(bus.gnt1), 64'h1);
        bus.sb_lock_m1 = 1'b0;
        step();

        // Non-preemption, then priority from idle
        bus.req1 = 1'b1;
        steps(2);
        check("tp_no_preempt", 64'(bus.gnt2), 64'h1);
        bus.req2 = 1'b0;
        step();
        bus.req1 = 1'b0;
        step();
        bus.req1 = 1'b1; bus.req2 = 1'b1;
        step();
        check("tp_tie_m1", 64'(bus.gnt1), 64'h1);

        // Split of M2 through S0's response, then release
        bus.req1 = 1'b0;
        steps(2);
        bus.resp0 = 2'b11;
        step();
        bus.resp0 = 2'b00;
        steps(2);
        check("tp_split_masked", 64'(bus.gnt2), 64'h0);
        bus.sb_split_ar = 2'b10;
        step();
        bus.sb_split_ar = 2'b00;
        step();
        check("tp_split_regrant", 64'(bus.gnt2), 64'h1);

        // Split set and release in the same cycle: set wins
        bus.resp = 2'b11; bus.sb_split_ar = 2'b10;
        step();
        bus.resp = 2'b00; bus.sb_split_ar = 2'b00;
        steps(2);
        bus.sb_split_ar = 2'b10;
        step();
        bus.sb_split_ar = 2'b00;
        step();

        // Retry drops to idle for a cycle; error has no effect
        bus.resp = 2'b10;
        step();
        bus.resp = 2'b00;
        step();
        bus.resp = 2'b01;
        steps(2);
        bus.resp = 2'b00;

        // Decoder sweep with M1
        bus.req2 = 1'b0; bus.req1 = 1'b1;
        step();
        bus.HADDR_M1 = 14'h1000;
        step();
        check("tp_dec_s1", 64'(bus.RDATA), 64'h1111_1111);
        bus.resp1 = 2'b11;
        step();
        bus.resp1 = 2'b00; bus.sb_split_ar = 2'b01;
        step();
        bus.sb_split_ar = 2'b00;
        step();
        bus.HADDR_M1 = 14'h2000;
        step();
        bus.HADDR_M1 = 14'h3000;
        step();
        check("tp_dec_hole", 64'(bus.sel_slave), 64'h3);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            bus.req1 = $urandom_range(0, 1) == 1;
            bus.req2 = $urandom_range(0, 1) == 1;
            bus.sb_lock_m1 = $urandom_range(0, 3) == 0;
            bus.sb_lock_m2 = $urandom_range(0, 3) == 0;
            bus.resp  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            bus.resp0 = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            bus.resp1 = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            bus.resp2 = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            bus.sb_split_ar = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            bus.HADDR_M1 = AW'($urandom);
            bus.HADDR_M2 = AW'($urandom);
            bus.WDATA_M1 = $urandom;
            bus.WDATA_M2 = $urandom;
            bus.RDATA_S0 = $urandom;
            bus.RDATA_S1 = $urandom;
            bus.RDATA_S2 = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
